// File: rtl/ml_pkg.sv
// Shared ML datapath types: activation selector and vector-walker FSM states.
package ml_pkg;

  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    RELU     = 2'd1,
    LEAKY    = 2'd2,
    CLAMP    = 2'd3
  } act_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } v_state_t;

  function automatic int num_chunks(input int len, input int lanes);
    return (len + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/v_act_lane.sv
// Combinational activation of one signed element: identity, ReLU, leaky ReLU or clamp.
module v_act_lane
  import ml_pkg::*;
#(
  parameter int NBits     = 16,
  parameter int LeakShift = 7,
  parameter int ClampBits = 8
) (
  input  logic [1:0]       i_mode,
  input  logic [NBits-1:0] i_x,
  output logic [NBits-1:0] o_y
);

  localparam logic signed [NBits-1:0] ClampMax =
    {{(NBits-ClampBits+1){1'b0}}, {(ClampBits-1){1'b1}}};
  localparam logic signed [NBits-1:0] ClampMin =
    {{(NBits-ClampBits+1){1'b1}}, {(ClampBits-1){1'b0}}};

  logic signed [NBits-1:0] w_x;
  logic signed [NBits-1:0] w_leak;

  assign w_x    = $signed(i_x);
  assign w_leak = w_x >>> LeakShift;

  always_comb begin
    o_y = i_x;
    case (act_mode_t'(i_mode))
      IDENTITY: o_y = i_x;
      RELU:     o_y = w_x[NBits-1] ? {NBits{1'b0}} : i_x;
      LEAKY:    o_y = w_x[NBits-1] ? w_leak : i_x;
      CLAMP: begin
        if (w_x > ClampMax) begin
          o_y = ClampMax;
        end else if (w_x < ClampMin) begin
          o_y = ClampMin;
        end else begin
          o_y = i_x;
        end
      end
      default:  o_y = i_x;
    endcase
  end

endmodule

// File: rtl/v_activation.sv
// Chunked vector activation: one registered output stage with ready/valid on both
// sides; the mode is captured with the first chunk and held for the whole vector.
module v_activation
  import ml_pkg::*;
#(
  parameter int InVecLength = 16,
  parameter int NBits       = 16,
  parameter int WorkingRegs = 4,
  parameter int LeakShift   = 7,
  parameter int ClampBits   = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [1:0]                   act_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WorkingRegs*NBits-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WorkingRegs*NBits-1:0] out_data,
  output logic [WorkingRegs-1:0]       out_lane_mask,
  output logic                         out_last,
  output logic                         busy
);

  localparam int NumChunks = num_chunks(InVecLength, WorkingRegs);
  localparam int LastLanes = InVecLength - (NumChunks - 1) * WorkingRegs;
  localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  logic [CntW-1:0]              r_cnt;
  v_state_t                     r_state;
  act_mode_t                    r_mode;
  logic                         r_out_valid;
  logic                         r_out_last;
  logic [WorkingRegs-1:0]       r_out_mask;
  logic [WorkingRegs*NBits-1:0] r_out_data;

  logic                         w_accept;
  logic                         w_first;
  logic                         w_last;
  logic [1:0]                   w_mode;
  logic [NBits-1:0]             w_lane_y [WorkingRegs];
  logic [WorkingRegs-1:0]       w_mask;
  logic [WorkingRegs*NBits-1:0] w_res;

  assign in_ready      = !r_out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_first       = (r_cnt == {CntW{1'b0}});
  assign w_last        = (r_cnt == CntW'(NumChunks - 1));
  // Chunk 0 uses the live selector; later chunks use the one captured with chunk 0.
  assign w_mode        = w_first ? act_mode : r_mode;

  assign out_valid     = r_out_valid;
  assign out_last      = r_out_last;
  assign out_lane_mask = r_out_mask;
  assign out_data      = r_out_data;
  assign busy          = (r_state == ACTIVE);

  for (genvar g = 0; g < WorkingRegs; g++) begin : g_lane
    v_act_lane #(
      .NBits    (NBits),
      .LeakShift(LeakShift),
      .ClampBits(ClampBits)
    ) u_lane (
      .i_mode(w_mode),
      .i_x   (in_data[g*NBits +: NBits]),
      .o_y   (w_lane_y[g])
    );
  end

  always_comb begin
    w_mask = '0;
    w_res  = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      w_mask[i] = !w_last || (i < LastLanes);
      w_res[i*NBits +: NBits] = w_mask[i] ? w_lane_y[i] : {NBits{1'b0}};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_state <= IDLE;
      r_mode  <= IDENTITY;
    end else if (w_accept) begin
      if (w_first) begin
        r_mode <= act_mode_t'(act_mode);
      end
      if (w_last) begin
        r_cnt   <= '0;
        r_state <= IDLE;
      end else begin
        r_cnt   <= r_cnt + CntW'(1);
        r_state <= ACTIVE;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_mask  <= '0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
      r_out_mask  <= w_mask;
      r_out_data  <= w_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_v_activation.sv
// Directed bench for v_activation with a chunk-level behavioural model (10 elements, 4 lanes).
module tb_v_activation;

  localparam int VEC_LEN   = 10;
  localparam int LANES     = 4;
  localparam int NB        = 16;
  localparam int CHUNKS    = (VEC_LEN + LANES - 1) / LANES;
  localparam int LEAK_DIV  = 128;
  localparam int CLAMP_HI  = 127;
  localparam int CLAMP_LO  = -128;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [1:0]      act_mode = 2'd0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [LANES*NB-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [LANES*NB-1:0] out_data;
  logic [LANES-1:0] out_lane_mask;
  logic            out_last;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // model state
  bit              m_valid = 1'b0;
  logic [63:0]     m_data  = '0;
  logic [3:0]      m_mask  = '0;
  bit              m_last  = 1'b0;
  bit              m_busy  = 1'b0;
  int              m_pos   = 0;
  logic [1:0]      m_mode  = 2'd0;

  v_activation #(
    .InVecLength(VEC_LEN),
    .NBits      (NB),
    .WorkingRegs(LANES),
    .LeakShift  (7),
    .ClampBits  (8)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .act_mode     (act_mode),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_lane_mask(out_lane_mask),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [15:0] b0, b1, b2, b3;
    b0 = 16'(a0); b1 = 16'(a1); b2 = 16'(a2); b3 = 16'(a3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic int act_ref(input int x, input logic [1:0] mode);
    case (mode)
      2'd0: return x;
      2'd1: return (x < 0) ? 0 : x;
      2'd2: return (x < 0) ? (x - (LEAK_DIV - 1)) / LEAK_DIV : x;
      2'd3: return (x > CLAMP_HI) ? CLAMP_HI : ((x < CLAMP_LO) ? CLAMP_LO : x);
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_mask = '0; m_last = 1'b0;
    m_busy = 1'b0; m_pos = 0; m_mode = 2'd0;
  endtask

  // Advance one clock: model decides from current inputs, then both step together.
  task automatic tick();
    bit acc;
    int pos, idx, x;
    logic [1:0] mu;
    logic [63:0] nd;
    logic [3:0] nm;
    acc = in_valid && (!m_valid || out_ready);
    pos = m_pos;
    mu  = (pos == 0) ? act_mode : m_mode;
    nd  = '0;
    nm  = '0;
    if (acc) begin
      for (int l = 0; l < LANES; l++) begin
        idx = pos * LANES + l;
        x   = $signed(in_data[l*NB +: NB]);
        if (idx < VEC_LEN) begin
          nm[l] = 1'b1;
          nd[l*NB +: NB] = 16'(act_ref(x, mu));
        end
      end
    end
    @(posedge clk_in);
    #1;
    if (acc) begin
      m_valid = 1'b1;
      m_data  = nd;
      m_mask  = nm;
      m_last  = (pos == CHUNKS - 1);
      m_busy  = (pos != CHUNKS - 1);
      m_mode  = mu;
      m_pos   = (pos == CHUNKS - 1) ? 0 : pos + 1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [1:0] mode, input logic [63:0] d);
    act_mode = mode;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk_in) begin
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_lane_mask", {60'd0, out_lane_mask}, {60'd0, m_mask});
      chk("out_last", {63'd0, out_last}, {63'd0, m_last});
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_mask", {60'd0, out_lane_mask}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Vector A: ReLU, selector switches to LEAKY after chunk 0 (must be ignored)
    send(2'd1, pack4(-256, 100, 0, -1));
    chk("relu_c0", out_data, pack4(0, 100, 0, 0));
    chk("relu_c0_valid", {63'd0, out_valid}, 64'd1);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    send(2'd2, pack4(5, -5, 32767, -32768));
    chk("relu_c1_held", out_data, pack4(5, 0, 32767, 0));
    send(2'd2, pack4(-7, 9, 1234, -1234));
    chk("last_data", out_data, pack4(0, 9, 0, 0));
    chk("last_mask", {60'd0, out_lane_mask}, 64'd3);
    chk("last_flag", {63'd0, out_last}, 64'd1);
    chk("busy_done", {63'd0, busy}, 64'd0);

    // Vector B: LEAKY, picked up from the new selector
    send(2'd2, pack4(-256, -1, 127, -32768));
    chk("leaky_c0", out_data, pack4(-2, -1, 127, -256));
    send(2'd0, pack4(-129, -128, 1000, -32767));
    chk("leaky_c1", out_data, pack4(-2, -1, 1000, -256));
    send(2'd0, pack4(-2, 3, 77, 88));

    // Vector C: clamp with 3 cycles of backpressure on chunk 1
    send(2'd3, pack4(300, -300, 5, -128));
    chk("clamp_c0", out_data, pack4(127, -128, 5, -128));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pack4(32767, -32768, 127, -129);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_data_hold", out_data, pack4(127, -128, 5, -128));
    end
    out_ready = 1'b1;
    tick();
    chk("clamp_c1", out_data, pack4(127, -128, 127, -128));
    in_data = pack4(-1000, 1000, 1, 2);
    tick();
    in_valid = 1'b0;
    chk("clamp_c2", out_data, pack4(-128, 127, 0, 0));
    tick();

    // Vector D: reset after chunk 1, then a clean full vector
    send(2'd1, pack4(1, 2, 3, 4));
    send(2'd1, pack4(5, 6, 7, 8));
    do_reset();
    send(2'd0, pack4(-9, 10, -11, 12));
    chk("post_reset_first_last", {63'd0, out_last}, 64'd0);
    chk("post_reset_first_data", out_data, pack4(-9, 10, -11, 12));
    send(2'd1, pack4(-1, 1, -1, 1));
    send(2'd1, pack4(400, -400, 9, 9));
    chk("post_reset_done_last", {63'd0, out_last}, 64'd1);
    chk("post_reset_done_data", out_data, pack4(400, -400, 0, 0));

    // Vector E/F: irregular valid/ready pattern in identity and clamp
    for (int k = 0; k < 14; k++) begin
      act_mode  = (k < 7) ? 2'd0 : 2'd3;
      in_valid  = (k % 3) != 1;
      out_ready = (k % 4) != 2;
      in_data   = pack4(k * 100 - 500, -k * 37, k * 3000 - 20000, k - 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v_activation.md
V_ACTIVATION -- requirements
Module: v_activation

Interface
REQ-001 SHALL have parameter InVecLength, default 16, elements per vector (>=1).
REQ-002 SHALL have parameter NBits, default 16, signed element width.
REQ-003 SHALL have parameter WorkingRegs, default 4, lanes per chunk (>=1).
REQ-004 SHALL have parameter LeakShift, default 7, leaky-ReLU arithmetic right shift (0..NBits-1).
REQ-005 SHALL have parameter ClampBits, default 8, signed saturation width for clamp mode (2..NBits).
REQ-006 SHALL have port clk_in  input  1  the only clock; all state on its rising edge.
REQ-007 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port act_mode  input  2  activation select (0 identity, 1 ReLU, 2 leaky ReLU, 3 clamp).
REQ-009 SHALL have port in_valid  input  1  in_data holds a chunk.
REQ-010 SHALL have port in_ready  output  1  block accepts a chunk this cycle.
REQ-011 SHALL have port in_data  input  WorkingRegs x NBits signed  input chunk; lane 0 is the lowest vector index.
REQ-012 SHALL have port out_valid  output  1  out_data holds a result chunk.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result chunk.
REQ-014 SHALL have port out_data  output  WorkingRegs x NBits signed  result chunk.
REQ-015 SHALL have port out_lane_mask  output  WorkingRegs  bit i set when lane i holds a real vector element.
REQ-016 SHALL have port out_last  output  1  result chunk is the final chunk of its vector.
REQ-017 SHALL have port busy  output  1  a vector is partially accepted (state ACTIVE).

Function
REQ-018 SHALL transfer input on in_valid&&in_ready and output on out_valid&&out_ready.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (single registered output stage, no combinational path from in_data to out_data).
REQ-020 SHALL present the result of an accepted chunk on out_data with out_valid high exactly one cycle after acceptance.
REQ-021 SHALL hold out_data, out_lane_mask and out_last stable while out_valid && !out_ready.
REQ-022 SHALL split each vector into NumChunks = ceil(InVecLength/WorkingRegs) chunks, tracked by a chunk counter 0..NumChunks-1.
REQ-023 SHALL implement FSM IDLE->ACTIVE on acceptance of chunk 0 when NumChunks>1, ACTIVE->IDLE on acceptance of chunk NumChunks-1; if NumChunks==1, stay in IDLE.
REQ-024 SHALL latch act_mode on acceptance of chunk 0 and use the latched mode for every chunk of that vector; act_mode changes mid-vector SHALL be ignored.
REQ-025 SHALL set out_last on the result of chunk NumChunks-1, and wrap the chunk counter to 0 there.
REQ-026 SHALL, on the last chunk, clear out_lane_mask bits and force out_data to 0 for lanes with index >= InVecLength - (NumChunks-1)*WorkingRegs; all other chunks SHALL have all mask bits set.
REQ-027 SHALL compute identity as y=x; ReLU as y = x<0 ? 0 : x.
REQ-028 SHALL compute leaky ReLU as y = x<0 ? (x >>> LeakShift) : x, arithmetic shift (rounds toward minus infinity, -1 stays -1).
REQ-029 SHALL compute clamp as x saturated to [-2^(ClampBits-1), 2^(ClampBits-1)-1].
REQ-030 SHALL produce results at NBits width with no overflow in any mode.

Reset
REQ-031 SHALL, on rst_in high, asynchronously force state IDLE, chunk counter 0, latched mode 0, out_valid 0, out_last 0, out_lane_mask 0, out_data 0, busy 0.
REQ-032 SHALL drop any partially transferred vector on reset mid-operation; the first chunk accepted after reset SHALL be treated as chunk 0.
REQ-033 SHALL hold in_ready high while rst_in is low and out_valid is low (accepts immediately after reset release).

Structure
REQ-034 SHALL take act_mode_t (IDENTITY, RELU, LEAKY, CLAMP) and the FSM state typedef from the shared ml_pkg package.
REQ-035 SHALL instantiate WorkingRegs copies of sub-module v_act_lane (combinational single-element activation, parameters NBits, LeakShift, ClampBits).

Verification (InVecLength=10, WorkingRegs=4, NBits=16, LeakShift=7, ClampBits=8)
REQ-036 SHALL cover ReLU: chunk {-256,100,0,-1} -> next cycle out_data {0,100,0,0}, out_valid 1.
REQ-037 SHALL cover leaky: {-256,-1,127,-32768} -> {-2,-1,127,-256}; clamp: {300,-300,5,-128} -> {127,-128,5,-128}.
REQ-038 SHALL cover a full vector of 3 chunks -> third result has out_last 1, out_lane_mask 0011, lanes 2,3 = 0; busy falls after third acceptance.
REQ-039 SHALL cover backpressure: out_ready low 3 cycles with in_valid high -> in_ready low, out_data unchanged, no chunk lost or duplicated.
REQ-040 SHALL cover mode switch RELU->LEAKY after chunk 0 -> chunks 1,2 still ReLU; next vector uses LEAKY.
REQ-041 SHALL cover reset asserted after chunk 1 -> out_valid 0 at once; next accepted chunk has out_last 0 and the vector completes after 3 more chunks.
